// File: rtl/timer_cmp_irq.sv
// Compare/interrupt unit: raises a level irq when the ms count reaches a programmed compare value.
// Latency: register reads return one cycle after re; a match sets pending at that edge, irq follows it.
// Backpressure: none; the MMIO strobes are accepted every cycle and a read never stalls.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active low
//   time_ms  free-running 32-bit millisecond count
//   re/we    register read / write strobes
//   addr     word address: 0 TIME(RO) 1 CMP 2 PERIOD 3 CTRL 4 STATUS, 5..7 read 0
//   wdata    write data
//   rdata    registered read data, holds its value while re is low
//   irq      level interrupt = pending & CTRL.irq_en
//
// Build option: define TIMER_CMP_MISS_CNT_EN to add a saturating missed-event
// counter in STATUS[MISS_W+7:8]; without it STATUS[31:1] reads 0.

module timer_cmp_irq #(
    parameter int ADDR_W = 3,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       time_ms,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

    // Register map
    localparam logic [ADDR_W-1:0] A_TIME   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CMP    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    // CTRL bit positions
    localparam int C_EN  = 0;
    localparam int C_PER = 1;
    localparam int C_IRQ = 2;

    logic [31:0] cmp_q;
    logic [31:0] period_q;
    logic [2:0]  ctrl_q;
    logic        pending_q;
    logic [1:0]  state_q;

    logic        wr_cmp;
    logic        wr_period;
    logic        wr_ctrl;
    logic        wr_status;
    logic [31:0] diff;
    logic        hit;
    logic        fire;
    logic        reload;
    logic [31:0] status_word;

    assign wr_cmp    = we && (addr == A_CMP);
    assign wr_period = we && (addr == A_PERIOD);
    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_status = we && (addr == A_STATUS);

    // Wrap-safe match: the count has reached CMP when the modular difference
    // is non-negative as a signed value. Valid while CMP stays within 2^31 ms
    // ahead of time_ms, which covers the 2^32 rollover.
    assign diff = time_ms - cmp_q;
    assign hit  = ($signed(diff) >= 0);

    // Fire is evaluated on the register values held before this edge, so a
    // CPU write in the same cycle never changes whether this edge fires.
    assign fire = (state_q == ST_ARMED) && hit;

    // Periodic with a non-zero period re-arms by advancing CMP; a zero period
    // behaves as one-shot so the unit cannot fire on every cycle forever.
    assign reload = ctrl_q[C_PER] && (period_q != 32'd0);

    // ------------------------------------------------------------------
    // CMP / PERIOD / CTRL
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmp_q    <= 32'd0;
            period_q <= 32'd0;
            ctrl_q   <= 3'd0;
        end else begin
            // CPU write wins over the auto-increment of the same edge.
            if (wr_cmp) begin
                cmp_q <= wdata;
            end else if (fire && reload) begin
                cmp_q <= cmp_q + period_q;
            end

            if (wr_period) begin
                period_q <= wdata;
            end

            if (wr_ctrl) begin
                ctrl_q <= wdata[2:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            if (wr_ctrl) begin
                // Writing CTRL always decides the state: enable re-arms
                // (even from FIRED), disable parks in IDLE.
                state_q <= wdata[C_EN] ? ST_ARMED : ST_IDLE;
            end else if (wr_cmp && ctrl_q[C_EN]) begin
                // A new compare value while enabled starts a fresh match.
                state_q <= ST_ARMED;
            end else if (fire) begin
                state_q <= reload ? ST_ARMED : ST_FIRED;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending flag: set by fire, write-1-to-clear; fire wins a collision.
    // Disabling the unit deliberately leaves it alone.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= 1'b0;
        end else if (fire) begin
            pending_q <= 1'b1;
        end else if (wr_status && wdata[0]) begin
            pending_q <= 1'b0;
        end
    end

`ifdef TIMER_CMP_MISS_CNT_EN
    // ------------------------------------------------------------------
    // Missed-event counter: counts fires that land while pending is still
    // set, i.e. events the CPU has not yet acknowledged.
    // ------------------------------------------------------------------
    localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

    logic [MISS_W-1:0] miss_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            miss_q <= '0;
        end else if (wr_status) begin
            // A fire colliding with the acknowledge is absorbed by the new
            // pending; the count is left as it was rather than cleared.
            if (!(fire && wdata[0])) begin
                miss_q <= '0;
            end
        end else if (fire && pending_q && (miss_q != MISS_MAX)) begin
            miss_q <= miss_q + 1'b1;
        end
    end

    always_comb begin
        status_word               = 32'd0;
        status_word[0]            = pending_q;
        status_word[MISS_W+7:8]   = miss_q;
    end
`else
    always_comb begin
        status_word    = 32'd0;
        status_word[0] = pending_q;
    end
`endif

    // ------------------------------------------------------------------
    // Read port: registered, holds while re is low. A write in the same
    // cycle is not visible until the following read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= 32'd0;
        end else if (re) begin
            case (addr)
                A_TIME:   rdata <= time_ms;
                A_CMP:    rdata <= cmp_q;
                A_PERIOD: rdata <= period_q;
                A_CTRL:   rdata <= {29'd0, ctrl_q};
                A_STATUS: rdata <= status_word;
                default:  rdata <= 32'd0;
            endcase
        end
    end

    assign irq = pending_q && ctrl_q[C_IRQ];

endmodule
